step_fifo_dev: RTL and testbench

- Bus peripheral for the dev4 slot (0xD400-0xD4FF) of the CPU address decoder.
- The CPU queues motion segments, each defined by {period, count, dir}, into a small FIFO.
- A step generator pops the segments and emits step/dir pulses to the motor driver.
- `ack` stalls the CPU when it commits a segment while the FIFO is full.

---
 rtl/step_fifo_dev_if.sv | 14 +
 rtl/step_fifo_dev.sv | 157 +++++++++++++++
 tb/tb_step_fifo_dev.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_fifo_dev_if.sv
// CPU-side register bus for the step FIFO peripheral (dev4 decoder slot).
// ack is combinational from the slave; dout is registered in the slave.
interface step_fifo_dev_if;
    logic [2:0] addr;
    logic [7:0] din;
    logic       stb;
    logic       wr;
    logic       rd;
    logic [7:0] dout;
    logic       ack;

    modport master (output addr, din, stb, wr, rd, input dout, ack);
    modport slave  (input addr, din, stb, wr, rd, output dout, ack);
endinterface

// File: rtl/step_fifo_dev.sv
// Stepper segment queue: the CPU stages {period, count, dir} and commits them into a FIFO;
// a small FSM pops each segment and emits PULSE_W-wide step pulses every max(period, PULSE_W+1) clocks.
module step_fifo_dev #(
    parameter int DEPTH   = 8,
    parameter int PULSE_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    step_fifo_dev_if.slave bus,
    output logic           step,
    output logic           dir,
    output logic           busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [15:0] PMIN = 16'(PULSE_W + 1);

    typedef struct packed {
        logic [15:0] period;
        logic [15:0] count;
        logic        dir;
    } seg_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    logic [15:0] period_stage, count_stage;
    logic        enable;
    seg_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    seg_t        cur;
    state_t      state;
    logic [15:0] remaining, timer, pe, rem_next;
    logic [CW-1:0] pcnt;
    logic        full, empty, pop, wr_hit, flush, push, step_next;
    logic [7:0]  status;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign pop   = (state == IDLE) && enable && !empty && !flush;

    // A pop in the same cycle frees a slot, so a commit into a full FIFO need not stall then.
    assign bus.ack = !(bus.stb && bus.wr && bus.addr == 3'd4 && full && !pop);
    assign wr_hit  = bus.stb && bus.wr && bus.ack;
    assign flush   = wr_hit && bus.addr == 3'd5 && bus.din[1];
    assign push    = wr_hit && bus.addr == 3'd4 && !flush;

    assign pe        = (cur.period < PMIN) ? PMIN : cur.period;
    assign rem_next  = (timer == 16'd0 && remaining != 16'd0) ? remaining - 16'd1 : remaining;
    assign step_next = step ? (pcnt != '0) : (timer == 16'd1 && remaining != 16'd0);
    assign status    = {full, empty, busy, dir, 4'(level)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_stage <= '0;
            count_stage  <= '0;
            enable       <= 1'b0;
        end else if (wr_hit) begin
            case (bus.addr)
                3'd0:    period_stage[7:0]  <= bus.din;
                3'd1:    period_stage[15:8] <= bus.din;
                3'd2:    count_stage[7:0]   <= bus.din;
                3'd3:    count_stage[15:8]  <= bus.din;
                3'd5:    enable             <= bus.din[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {period_stage, count_stage, bus.din[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= '0;
            dir       <= 1'b0;
            remaining <= '0;
            timer     <= '0;
            step      <= 1'b0;
            pcnt      <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (state != IDLE) || !empty;
            if (flush) begin
                state     <= IDLE;
                step      <= 1'b0;
                pcnt      <= '0;
                remaining <= '0;
                timer     <= '0;
            end else begin
                case (state)
                    IDLE: if (pop) begin
                        cur   <= mem[rd_ptr];
                        state <= LOAD;
                    end
                    LOAD: begin
                        dir       <= cur.dir;
                        remaining <= cur.count;
                        timer     <= pe - 16'd1;
                        state     <= (cur.count == 16'd0) ? IDLE : RUN;
                    end
                    RUN: begin
                        timer     <= (timer == 16'd0) ? pe - 16'd1 : timer - 16'd1;
                        remaining <= rem_next;
                        // Registered step rises one clock after timer==1, i.e. in the timer==0 cycle.
                        if (step) begin
                            if (pcnt == '0) step <= 1'b0;
                            else            pcnt <= pcnt - CW'(1);
                        end else if (step_next) begin
                            step <= 1'b1;
                            pcnt <= CW'(PULSE_W - 1);
                        end
                        if (rem_next == 16'd0 && !step_next) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dout <= '0;
        end else if (bus.stb && bus.rd && bus.ack) begin
            case (bus.addr)
                3'd0:    bus.dout <= status;
                3'd1:    bus.dout <= remaining[7:0];
                3'd2:    bus.dout <= remaining[15:8];
                3'd5:    bus.dout <= {7'b0, enable};
                default: bus.dout <= 8'h00;
            endcase
        end
    end
endmodule

// File: tb/tb_step_fifo_dev.sv
// Bench for step_fifo_dev: queues segments, predicts step rise cycles from the segment timing
// rules (LOAD cycle, pe, IDLE+LOAD gaps) and compares against the observed pulse train.
module tb_step_fifo_dev;
    localparam int DEPTH = 8;
    localparam int PW    = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic step, dir, busy;

    step_fifo_dev_if bus();

    step_fifo_dev #(.DEPTH(DEPTH), .PULSE_W(PW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .step(step), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec_cnt = 0, err_cnt = 0;
    int wcyc, rcyc;
    logic [7:0] rdata;
    logic model_dir = 1'b0;
    int sp[8], sc[8];
    logic sd[8];

    // Pulse monitor: rise cycle, dir at rise and high width of every step pulse.
    int rise_q[$], width_q[$];
    logic rdir_q[$];
    logic prev_step = 1'b0;
    int hi_len = 0;
    always @(negedge clk) begin
        if (step && !prev_step) begin
            rise_q.push_back(cyc);
            rdir_q.push_back(dir);
            hi_len = 1;
        end else if (step) begin
            hi_len++;
        end else if (prev_step) begin
            width_q.push_back(hi_len);
        end
        prev_step = step;
    end

    task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a; bus.din = d; bus.stb = 1'b1; bus.wr = 1'b1;
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.wr = 1'b0;
        wcyc = cyc;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        @(negedge clk);
        bus.addr = a; bus.stb = 1'b1; bus.rd = 1'b1;
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.rd = 1'b0;
        rdata = bus.dout;
        rcyc = cyc;
    endtask

    task automatic push_seg(input int p, input int c, input logic d);
        bus_wr(3'd0, p[7:0]);
        bus_wr(3'd1, p[15:8]);
        bus_wr(3'd2, c[7:0]);
        bus_wr(3'd3, c[15:8]);
        bus_wr(3'd4, {7'b0, d});
    endtask

    // Queue n segments from sp/sc/sd with enable low, then enable and check the whole pulse train.
    task automatic run_segs(input int n, input string tag);
        int exp_rise[$];
        logic exp_dir[$];
        int L, pe;
        logic [7:0] st;
        for (int i = 0; i < n; i++) push_seg(sp[i], sc[i], sd[i]);
        rise_q.delete(); width_q.delete(); rdir_q.delete();
        bus_wr(3'd5, 8'h01);
        L = wcyc + 1;
        for (int i = 0; i < n; i++) begin
            pe = (sp[i] < PW + 1) ? PW + 1 : sp[i];
            for (int k = 1; k <= sc[i]; k++) begin
                exp_rise.push_back(L + k * pe);
                exp_dir.push_back(sd[i]);
            end
            model_dir = sd[i];
            L = (sc[i] == 0) ? L + 2 : L + sc[i] * pe + PW + 1;
        end
        while (cyc < L + 2) @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++; $display("FAIL %s busy_end: got %b expected 0", tag, busy);
        end
        vec_cnt++;
        if (rise_q.size() != exp_rise.size()) begin
            err_cnt++;
            $display("FAIL %s pulse_count: got %0d expected %0d", tag, rise_q.size(), exp_rise.size());
        end
        for (int i = 0; i < exp_rise.size() && i < rise_q.size(); i++) begin
            vec_cnt++;
            if (rise_q[i] != exp_rise[i]) begin
                err_cnt++; $display("FAIL %s rise%0d: got cycle %0d expected %0d", tag, i, rise_q[i], exp_rise[i]);
            end
            vec_cnt++;
            if (rdir_q[i] !== exp_dir[i]) begin
                err_cnt++; $display("FAIL %s dir%0d: got %b expected %b", tag, i, rdir_q[i], exp_dir[i]);
            end
            if (i < width_q.size()) begin
                vec_cnt++;
                if (width_q[i] != PW) begin
                    err_cnt++; $display("FAIL %s width%0d: got %0d expected %0d", tag, i, width_q[i], PW);
                end
            end
        end
        bus_wr(3'd5, 8'h00);
        // Idle status: empty set, busy/full clear, dir field shows the last loaded direction.
        bus_rd(3'd0);
        st = {1'b0, 1'b1, 1'b0, model_dir, 4'd0};
        vec_cnt++;
        if (rdata !== st) begin
            err_cnt++; $display("FAIL %s status_end: got %h expected %h", tag, rdata, st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({step, dir, busy} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_outputs: got %b expected 000", {step, dir, busy});
        end
        vec_cnt++;
        if (bus.dout !== 8'h00) begin
            err_cnt++; $display("FAIL reset_dout: got %h expected 00", bus.dout);
        end
        vec_cnt++;
        if (bus.ack !== 1'b1) begin
            err_cnt++; $display("FAIL reset_ack: got %b expected 1", bus.ack);
        end
        reset = 1'b1;
        bus_rd(3'd0);
        vec_cnt++;
        if (rdata !== 8'h40) begin
            err_cnt++; $display("FAIL reset_status: got %h expected 40", rdata);
        end
        bus_rd(3'd5);
        vec_cnt++;
        if (rdata !== 8'h00) begin
            err_cnt++; $display("FAIL reset_ctrl: got %h expected 00", rdata);
        end
    endtask

    task automatic test_single();
        sp[0] = 10; sc[0] = 3; sd[0] = 1'b1;
        run_segs(1, "single");
    endtask

    task automatic test_clamp_zero();
        sp[0] = 2; sc[0] = 2; sd[0] = 1'b0;
        sp[1] = 9; sc[1] = 0; sd[1] = 1'b1;
        sp[2] = 3; sc[2] = 1; sd[2] = 1'b0;
        sp[3] = 0; sc[3] = 2; sd[3] = 1'b1;
        run_segs(4, "clamp_zero");
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                sp[i] = $urandom_range(0, 25);
                sc[i] = $urandom_range(0, 3);
                sd[i] = 1'($urandom_range(0, 1));
            end
            run_segs(n, "random");
        end
    endtask

    task automatic test_full_stall();
        for (int i = 0; i < DEPTH; i++) push_seg(6, 1, 1'b1);
        bus_rd(3'd0);
        vec_cnt++;
        if (rdata !== {1'b1, 1'b0, 1'b1, model_dir, 4'd8}) begin
            err_cnt++; $display("FAIL full_status: got %h expected %h", rdata, {1'b1, 1'b0, 1'b1, model_dir, 4'd8});
        end
        @(negedge clk);
        bus.addr = 3'd4; bus.din = 8'h01; bus.stb = 1'b1; bus.wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++;
            if (bus.ack !== 1'b0) begin
                err_cnt++; $display("FAIL full_ack_stall%0d: got %b expected 0", i, bus.ack);
            end
            @(negedge clk);
        end
        bus.stb = 1'b0; bus.wr = 1'b0;
        bus_wr(3'd5, 8'h01);
        // The IDLE pop happens in this cycle, so the held commit now completes.
        bus.addr = 3'd4; bus.din = 8'h01; bus.stb = 1'b1; bus.wr = 1'b1;
        #1;
        vec_cnt++;
        if (bus.ack !== 1'b1) begin
            err_cnt++; $display("FAIL full_ack_pop: got %b expected 1", bus.ack);
        end
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.wr = 1'b0;
        bus_rd(3'd0);
        vec_cnt++;
        if ({rdata[7], rdata[3:0]} !== 5'b1_1000) begin
            err_cnt++; $display("FAIL full_level_kept: got %h expected full=1 level=8", rdata);
        end
        bus_wr(3'd5, 8'h02);
        model_dir = 1'b1;
        repeat (2) @(negedge clk);
        bus_rd(3'd0);
        vec_cnt++;
        if (rdata !== 8'h50) begin
            err_cnt++; $display("FAIL full_flush_status: got %h expected 50", rdata);
        end
    endtask

    task automatic test_readback_flush();
        int L, n, k;
        logic [15:0] exp;
        push_seg(20, 16'h0102, 1'b0);
        bus_wr(3'd5, 8'h01);
        L = wcyc + 1;
        model_dir = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            repeat (35 + pass * 47) @(negedge clk);
            bus_rd(3'd1);
            n = rcyc - 1;
            exp = 16'h0102 - 16'((n - L - 1) / 20);
            vec_cnt++;
            if (rdata !== exp[7:0]) begin
                err_cnt++; $display("FAIL readback_lo%0d: got %h expected %h", pass, rdata, exp[7:0]);
            end
            bus_rd(3'd2);
            n = rcyc - 1;
            exp = 16'h0102 - 16'((n - L - 1) / 20);
            vec_cnt++;
            if (rdata !== exp[15:8]) begin
                err_cnt++; $display("FAIL readback_hi%0d: got %h expected %h", pass, rdata, exp[15:8]);
            end
        end
        k = 0;
        while (!step && k < 100) begin @(negedge clk); k++; end
        vec_cnt++;
        if (k >= 100) begin
            err_cnt++; $display("FAIL flush_wait_step: got no step in %0d cycles expected a pulse", k);
        end
        bus_wr(3'd5, 8'h03);
        @(negedge clk);
        vec_cnt++;
        if (step !== 1'b0) begin
            err_cnt++; $display("FAIL flush_step: got %b expected 0", step);
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++; $display("FAIL flush_busy: got %b expected 0", busy);
        end
        bus_rd(3'd0);
        vec_cnt++;
        if (rdata !== 8'h40) begin
            err_cnt++; $display("FAIL flush_status: got %h expected 40", rdata);
        end
        bus_rd(3'd1);
        vec_cnt++;
        if (rdata !== 8'h00) begin
            err_cnt++; $display("FAIL flush_remaining: got %h expected 00", rdata);
        end
        bus_wr(3'd5, 8'h00);
    endtask

    task automatic test_async_reset();
        int k;
        push_seg(8, 3, 1'b1);
        bus_wr(3'd5, 8'h01);
        bus_rd(3'd5);
        vec_cnt++;
        if (rdata !== 8'h01) begin
            err_cnt++; $display("FAIL ctrl_readback: got %h expected 01", rdata);
        end
        k = 0;
        while (!step && k < 100) begin @(negedge clk); k++; end
        vec_cnt++;
        if (k >= 100) begin
            err_cnt++; $display("FAIL areset_wait_step: got no step in %0d cycles expected a pulse", k);
        end
        #2 reset = 1'b0;
        #1;
        vec_cnt++;
        if ({step, dir, busy} !== 3'b000) begin
            err_cnt++; $display("FAIL areset_outputs: got %b expected 000", {step, dir, busy});
        end
        vec_cnt++;
        if (bus.dout !== 8'h00) begin
            err_cnt++; $display("FAIL areset_dout: got %h expected 00", bus.dout);
        end
        model_dir = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus_rd(3'd0);
        vec_cnt++;
        if (rdata !== 8'h40) begin
            err_cnt++; $display("FAIL areset_status: got %h expected 40", rdata);
        end
        bus_rd(3'd5);
        vec_cnt++;
        if (rdata !== 8'h00) begin
            err_cnt++; $display("FAIL areset_ctrl: got %h expected 00", rdata);
        end
        repeat (12) @(negedge clk);
        vec_cnt++;
        if (step !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL areset_idle: got step=%b busy=%b expected 0 0", step, busy);
        end
    endtask

    initial begin
        bus.addr = 3'd0; bus.din = 8'h00; bus.stb = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
        test_reset();
        test_single();
        test_clamp_zero();
        test_random();
        test_full_stall();
        test_readback_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
